jpeg_dequantizer: RTL and testbench

Inverse of the coder's quantizer, for the decoder path. Accepts a stream of 64 quantized coefficients per 8×8 block, multiplies each by its quantization-table entry, and writes the reconstructed DCT coefficient into the IDCT input buffer through a `ramWr_if` transmit port. Sits between the entropy decoder and the IDCT; signals block completion so the buffer can be swapped.

---
 rtl/jpeg_pkg.sv | 55 +++++
 rtl/ramWr_if.sv | 16 +
 rtl/jpeg_dequantizer_sat_mult.sv | 29 ++
 rtl/jpeg_dequantizer.sv | 136 +++++++++++++
 tb/tb_jpeg_dequantizer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_pkg : shared JPEG quantisation/zigzag tables and dequantizer states |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package jpeg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } deq_state_e;

  // Standard tables (Annex K.1 / K.2), raster order.
  localparam logic [7:0] LUMA_Q [64] = '{
     16,  11,  10,  16,  24,  40,  51,  61,
     12,  12,  14,  19,  26,  58,  60,  55,
     14,  13,  16,  24,  40,  57,  69,  56,
     14,  17,  22,  29,  51,  87,  80,  62,
     18,  22,  37,  56,  68, 109, 103,  77,
     24,  35,  55,  64,  81, 104, 113,  92,
     49,  64,  78,  87, 103, 121, 120, 101,
     72,  92,  95,  98, 112, 100, 103,  99
  };

  localparam logic [7:0] CHROMA_Q [64] = '{
     17,  18,  24,  47,  99,  99,  99,  99,
     18,  21,  26,  66,  99,  99,  99,  99,
     24,  26,  56,  99,  99,  99,  99,  99,
     47,  66,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99,
     99,  99,  99,  99,  99,  99,  99,  99
  };

  // Stream index -> raster address.
  localparam logic [5:0] ZIGZAG [64] = '{
      0,  1,  8, 16,  9,  2,  3, 10,
     17, 24, 32, 25, 18, 11,  4,  5,
     12, 19, 26, 33, 40, 48, 41, 34,
     27, 20, 13,  6,  7, 14, 21, 28,
     35, 42, 49, 56, 57, 50, 43, 36,
     29, 22, 15, 23, 30, 37, 44, 51,
     58, 59, 52, 45, 38, 31, 39, 46,
     53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [7:0] q_lookup(input logic chroma, input logic [5:0] addr);
    return chroma ? CHROMA_Q[addr] : LUMA_Q[addr];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramWr_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ramWr_if : single-port write bus into the IDCT coefficient buffer        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface ramWr_if #(
  parameter int DATA_W = 12
);
  logic                     en;
  logic [5:0]               addr;
  logic signed [DATA_W-1:0] data;

  modport Tx (output en, addr, data);
  modport Rx (input  en, addr, data);
endinterface
`default_nettype wire

// File: rtl/jpeg_dequantizer_sat_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_mult : signed x unsigned-8 multiply, saturated to OUT_WIDTH          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sat_mult #(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 12
) (
  input  wire logic signed [IN_WIDTH-1:0]  i_a,
  input  wire logic        [7:0]           i_q,
  output logic      signed [OUT_WIDTH-1:0] o_y
);
  localparam int P_W = IN_WIDTH + 9;
  localparam logic signed [P_W-1:0] c_max = (P_W)'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [P_W-1:0] c_min = ~c_max;

  logic signed [P_W-1:0] w_prod;

  // Zero-extend the table entry so it multiplies as a positive signed value.
  assign w_prod = $signed(i_a) * $signed({1'b0, i_q});

  always_comb begin
    if (w_prod > c_max)      o_y = c_max[OUT_WIDTH-1:0];
    else if (w_prod < c_min) o_y = c_min[OUT_WIDTH-1:0];
    else                     o_y = w_prod[OUT_WIDTH-1:0];
  end
endmodule
`default_nettype wire

// File: rtl/jpeg_dequantizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jpeg_dequantizer : 8x8 block dequantizer feeding the IDCT buffer         |
// | Option macro DEQUANT_ZIGZAG_EN : input in zigzag order.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jpeg_dequantizer
  import jpeg_pkg::*;
#(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 12,
  parameter int CHROMA    = 0
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       in_valid,
  output logic                            in_ready,
  input  wire logic signed [IN_WIDTH-1:0] in_data,
  input  wire logic                       buf_free,
  ramWr_if.Tx                             out,
  output logic                            blk_done
);
  localparam logic c_chroma_sel = (CHROMA != 0);

  deq_state_e r_state;
  logic [5:0] r_cnt;
  logic       r_flush;
  logic       r_blk_done;

  logic                       r_s1_vld;
  logic signed [IN_WIDTH-1:0] r_s1_data;
  logic [5:0]                 r_s1_addr;
  logic [7:0]                 r_s1_q;

  logic                        r_out_en;
  logic [5:0]                  r_out_addr;
  logic signed [OUT_WIDTH-1:0] r_out_data;

  logic                        w_xfer;
  logic [5:0]                  w_addr;
  logic signed [OUT_WIDTH-1:0] w_sat;

  always_comb begin
    case (r_state)
      IDLE:    in_ready = buf_free;
      RUN:     in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_xfer = in_valid && in_ready;

`ifdef DEQUANT_ZIGZAG_EN
  assign w_addr = ZIGZAG[r_cnt];
`else
  assign w_addr = r_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_flush    <= 1'b0;
      r_blk_done <= 1'b0;
    end else begin
      r_blk_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state <= RUN;
            r_cnt   <= 6'd1;
          end
        end
        RUN: begin
          if (w_xfer) begin
            // Index 63 wraps naturally to 0 for the next block.
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd63) begin
              r_state <= FLUSH;
              r_flush <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (r_flush) begin
            r_state    <= DONE;
            r_flush    <= 1'b0;
            r_blk_done <= 1'b1;
          end else begin
            r_flush <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_addr  <= '0;
      r_s1_q     <= '0;
      r_out_en   <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_s1_vld <= w_xfer;
      if (w_xfer) begin
        r_s1_data <= in_data;
        r_s1_addr <= w_addr;
        r_s1_q    <= q_lookup(c_chroma_sel, w_addr);
      end
      r_out_en <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_addr <= r_s1_addr;
        r_out_data <= w_sat;
      end
    end
  end

  sat_mult #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_mult (
    .i_a (r_s1_data),
    .i_q (r_s1_q),
    .o_y (w_sat)
  );

  assign out.en   = r_out_en;
  assign out.addr = r_out_addr;
  assign out.data = r_out_data;
  assign blk_done = r_blk_done;
endmodule
`default_nettype wire

// File: tb/tb_jpeg_dequantizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jpeg_dequantizer : luma and chroma instances against a block model    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_jpeg_dequantizer;
  localparam int IN_W  = 10;
  localparam int OUT_W = 12;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic in_valid = 1'b0;
  logic buf_free = 1'b0;
  logic signed [IN_W-1:0] in_data = '0;
  logic rdy0, rdy1, done0, done1;

  ramWr_if #(.DATA_W(OUT_W)) if0 ();
  ramWr_if #(.DATA_W(OUT_W)) if1 ();

  jpeg_dequantizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CHROMA(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .buf_free(buf_free), .out(if0), .blk_done(done0)
  );

  jpeg_dequantizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CHROMA(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .buf_free(buf_free), .out(if1), .blk_done(done1)
  );

  always #5 clk = ~clk;

  int luma_q [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68,109,103, 77,   24, 35, 55, 64, 81,104,113, 92,
    49, 64, 78, 87,103,121,120,101,   72, 92, 95, 98,112,100,103, 99
  };
  int chroma_top [16] = '{17, 18, 24, 47, 18, 21, 26, 66, 24, 26, 56, 99, 47, 66, 99, 99};
  int chroma_q [64];
  int zz [64];

  typedef struct {
    int due;
    int addr;
    int d0;
    int d1;
  } wr_t;

  wr_t q[$];
  wr_t e;
  int  cyc = 0;
  int  idx = 0;
  int  win_lo = -10, win_hi = -10, done_at = -10;
  int  n_done_exp = 0, n_done0 = 0;
  int  n_cmp = 0, n_mis = 0;
  bit  exp_en, exp_rdy;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    int hi = (1 << (OUT_W - 1)) - 1;
    int lo = -(1 << (OUT_W - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Tables: zigzag by walking anti-diagonals, chroma as 4x4 corner plus 99s.
  initial begin
    int k, r, c;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 8; j++) begin
        r = (s % 2 == 1) ? j : 7 - j;
        c = s - r;
        if (c >= 0 && c < 8) begin
          zz[k] = r * 8 + c;
          k++;
        end
      end
    end
    for (int a = 0; a < 64; a++)
      chroma_q[a] = ((a / 8) < 4 && (a % 8) < 4) ? chroma_top[(a / 8) * 4 + (a % 8)] : 99;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      idx = 0; win_lo = -10; win_hi = -10; done_at = -10;
      chk("rst_en0", int'(if0.en), 0);
      chk("rst_en1", int'(if1.en), 0);
      chk("rst_addr0", int'(if0.addr), 0);
      chk("rst_data0", int'(if0.data), 0);
      chk("rst_done0", int'(done0), 0);
      chk("rst_rdy0", int'(rdy0), int'(buf_free));
    end else begin
      exp_en = (q.size() > 0) && (q[0].due == cyc);
      chk("en0", int'(if0.en), int'(exp_en));
      chk("en1", int'(if1.en), int'(exp_en));
      if (exp_en) begin
        e = q.pop_front();
        chk("addr0", int'(if0.addr), e.addr);
        chk("data0", int'(if0.data), e.d0);
        chk("addr1", int'(if1.addr), e.addr);
        chk("data1", int'(if1.data), e.d1);
      end
      chk("done0", int'(done0), int'(cyc == done_at));
      chk("done1", int'(done1), int'(cyc == done_at));
      if (done0) n_done0++;
      exp_rdy = (cyc >= win_lo && cyc <= win_hi) ? 1'b0 : ((idx == 0) ? buf_free : 1'b1);
      chk("rdy0", int'(rdy0), int'(exp_rdy));
      chk("rdy1", int'(rdy1), int'(exp_rdy));
      if (in_valid && exp_rdy) begin
`ifdef DEQUANT_ZIGZAG_EN
        e.addr = zz[idx];
`else
        e.addr = idx;
`endif
        e.due = cyc + 2;
        e.d0  = sat(int'(in_data) * luma_q[e.addr]);
        e.d1  = sat(int'(in_data) * chroma_q[e.addr]);
        q.push_back(e);
        idx++;
        if (idx == 64) begin
          idx = 0;
          win_lo = cyc + 1; win_hi = cyc + 3; done_at = cyc + 3;
          n_done_exp++;
        end
      end
    end
  end

  function automatic logic signed [IN_W-1:0] stim(input int mode, input int n);
    case (mode)
      0:       return 1;
      1:       return (n == 2) ? 1 : 0;
      2:       return (n == 63) ? -512 : 0;
      3:       return (n == 63) ? 511 : 0;
      default: return IN_W'($urandom);
    endcase
  endfunction

  // Drives nxf transfers; gap_pct is the chance of a bubble per cycle.
  task automatic run_block(input int mode, input int gap_pct, input int nxf, input bit rnd_free);
    int n, guard;
    n = 0; guard = 0;
    while (n < nxf) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = stim(mode, n);
      if (rnd_free) buf_free = ($urandom_range(99) < 70);
      #1;
      if (in_valid && rdy0) n++;
      guard++;
      if (guard > 3000) begin
        chk("blk_timeout", n, nxf);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    buf_free = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    run_block(0, 0, 64, 1'b0);
    idle(6);
    run_block(1, 0, 64, 1'b0);
    idle(6);
    run_block(2, 0, 64, 1'b0);
    idle(6);
    run_block(3, 0, 64, 1'b0);
    idle(6);

    buf_free = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 1;
    end
    buf_free = 1'b1;
    run_block(0, 0, 64, 1'b0);
    idle(6);

    for (int b = 0; b < 3; b++) run_block(4, 30, 64, 1'b1);
    buf_free = 1'b1;
    idle(6);

    run_block(4, 20, 30, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_block(4, 10, 64, 1'b0);
    idle(8);

    chk("blk_done_count", n_done0, n_done_exp);
    chk("pending_writes", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
